// File: rtl/regfile_dump.sv
// Snapshots all registers on start_i and streams them out in index order, first beat one cycle after start.
// One beat per cycle; each beat (data/idx/last) holds stable while m_ready_i is low, including the last.
module regfile_dump #(
    parameter  int NUM_REGS  = 16,
    parameter  int REG_WIDTH = 32,
    localparam int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [NUM_REGS*REG_WIDTH-1:0] regs_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [REG_WIDTH-1:0]          m_data_o,
    output logic [IDX_W-1:0]              m_idx_o,
    output logic                          m_last_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_capture;
    logic                 w_hs;
    logic [REG_WIDTH-1:0] r_snap [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Snapshot is only written on the capture edge, so writers never disturb a dump in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_snap[k] <= '0;
            end
        end else if (w_capture) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_snap[k] <= regs_i[k*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        w_hs        = (r_state == S_SEND) && m_ready_i;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // All outputs decode registered state only; start_i and m_ready_i never reach them combinationally.
    assign busy_o    = (r_state == S_SEND);
    assign m_valid_o = (r_state == S_SEND);
    assign done_o    = r_done;
    assign m_last_o  = (r_state == S_SEND) && (r_idx == LAST_IDX);
    assign m_idx_o   = (r_state == S_SEND) ? r_idx : '0;
    assign m_data_o  = (r_state == S_SEND) ? r_snap[r_idx] : '0;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed scenarios plus a randomized run against a queue-based model.
module tb_regfile_dump;

    localparam int NR = 16;
    localparam int RW = 32;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            start_i   = 1'b0;
    logic            m_ready_i = 1'b0;
    logic [NR*RW-1:0] regs_i;
    logic [RW-1:0]   regs_m [NR];
    logic            busy_o;
    logic            done_o;
    logic            m_valid_o;
    logic            m_last_o;
    logic [RW-1:0]   m_data_o;
    logic [3:0]      m_idx_o;

    // Model: beats still owed by the current dump, front = next beat; empty means idle.
    logic [RW-1:0]   exp_q [$];
    logic            exp_done = 1'b0;
    int              n_cmp = 0;
    int              n_err = 0;

    regfile_dump #(.NUM_REGS(NR), .REG_WIDTH(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .regs_i    (regs_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_idx_o   (m_idx_o),
        .m_last_o  (m_last_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NR; k++) regs_i[k*RW +: RW] = regs_m[k];
    end

    function automatic logic [3:0] exp_idx();
        return 4'(NR - exp_q.size());
    endfunction

    // Advance the model across the coming rising edge using the inputs just driven.
    task automatic model_edge();
        bit was_busy;
        was_busy = (exp_q.size() != 0);
        exp_done = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            return;
        end
        if (was_busy && m_ready_i) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) exp_done = 1'b1;
        end
        if (!was_busy && start_i) begin
            for (int k = 0; k < NR; k++) exp_q.push_back(regs_m[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b1; m_ready_i = 1'b1;
        for (int k = 0; k < NR; k++) regs_m[k] = $urandom;
        repeat (3) begin
            @(negedge clk);
            model_edge();
        end
        @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, m_valid_o, m_last_o, m_idx_o, m_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_in: busy=%b done=%b valid=%b last=%b idx=%0d data=%h required all 0",
                     busy_o, done_o, m_valid_o, m_last_o, m_idx_o, m_data_o);
        end
        rst_n = 1'b1; start_i = 1'b0;
        model_edge();
        @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, m_valid_o, m_last_o, m_idx_o, m_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_out: busy=%b done=%b valid=%b last=%b idx=%0d data=%h required all 0",
                     busy_o, done_o, m_valid_o, m_last_o, m_idx_o, m_data_o);
        end
        model_edge();
    endtask

    task automatic test_basic();
        bit act;
        int busy_cnt = 0;
        for (int k = 0; k < NR; k++) regs_m[k] = 32'hA000_0000 + k;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            act = (exp_q.size() != 0);
            busy_cnt += int'(busy_o);
            n_cmp++;
            if ({busy_o, m_valid_o, done_o} !== {act, act, exp_done}) begin
                n_err++;
                $display("FAIL basic_ctrl c=%0d: busy/valid/done=%b%b%b required %b%b%b",
                         c, busy_o, m_valid_o, done_o, act, act, exp_done);
            end
            if (act) begin
                n_cmp++;
                if ({m_idx_o, m_data_o, m_last_o} !== {exp_idx(), exp_q[0], exp_idx() == 4'(NR-1)}) begin
                    n_err++;
                    $display("FAIL basic_beat c=%0d: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             c, m_idx_o, m_data_o, m_last_o, exp_idx(), exp_q[0], exp_idx() == 4'(NR-1));
                end
            end
            start_i = (c == 0); m_ready_i = 1'b1;
            model_edge();
        end
        n_cmp++;
        if (busy_cnt !== NR) begin
            n_err++;
            $display("FAIL basic_busy_len: busy cycles=%0d required %0d", busy_cnt, NR);
        end
    endtask

    task automatic test_coherence();
        bit act;
        for (int k = 0; k < NR; k++) regs_m[k] = 32'h1111_1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            act = (exp_q.size() != 0);
            n_cmp++;
            if ({busy_o, m_valid_o, done_o} !== {act, act, exp_done}) begin
                n_err++;
                $display("FAIL coh_ctrl c=%0d: busy/valid/done=%b%b%b required %b%b%b",
                         c, busy_o, m_valid_o, done_o, act, act, exp_done);
            end
            if (act) begin
                n_cmp++;
                if ({m_idx_o, m_data_o, m_last_o} !== {exp_idx(), 32'h1111_1111, exp_idx() == 4'(NR-1)}) begin
                    n_err++;
                    $display("FAIL coh_beat c=%0d: idx=%0d data=%h last=%b required idx=%0d data=11111111 last=%b",
                             c, m_idx_o, m_data_o, m_last_o, exp_idx(), exp_idx() == 4'(NR-1));
                end
            end
            start_i = (c == 0); m_ready_i = 1'b1;
            if (c == 1) for (int k = 0; k < NR; k++) regs_m[k] = 32'h2222_2222;
            model_edge();
        end
    endtask

    task automatic test_backpressure();
        bit act;
        int stall = 0;
        int dones = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < NR; k++) regs_m[k] = $urandom;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            act = (exp_q.size() != 0);
            dones += int'(done_o);
            n_cmp++;
            if ({busy_o, m_valid_o, done_o} !== {act, act, exp_done}) begin
                n_err++;
                $display("FAIL bp_ctrl c=%0d: busy/valid/done=%b%b%b required %b%b%b",
                         c, busy_o, m_valid_o, done_o, act, act, exp_done);
            end
            if (act) begin
                n_cmp++;
                if ({m_idx_o, m_data_o, m_last_o} !== {exp_idx(), exp_q[0], exp_idx() == 4'(NR-1)}) begin
                    n_err++;
                    $display("FAIL bp_beat c=%0d: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             c, m_idx_o, m_data_o, m_last_o, exp_idx(), exp_q[0], exp_idx() == 4'(NR-1));
                end
            end
            start_i = (c == 0);
            m_ready_i = pat[c % 4];
            if (act && exp_idx() == 4'(NR-1) && stall < 5) begin
                m_ready_i = 1'b0;
                stall++;
            end
            model_edge();
        end
        n_cmp++;
        if (dones !== 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_complete: done pulses=%0d beats left=%0d required 1 and 0", dones, exp_q.size());
        end
    endtask

    task automatic test_start_busy();
        bit act;
        int beats = 0;
        for (int k = 0; k < NR; k++) regs_m[k] = $urandom;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            act = (exp_q.size() != 0);
            n_cmp++;
            if ({busy_o, m_valid_o, done_o} !== {act, act, exp_done}) begin
                n_err++;
                $display("FAIL sb_ctrl c=%0d: busy/valid/done=%b%b%b required %b%b%b",
                         c, busy_o, m_valid_o, done_o, act, act, exp_done);
            end
            if (act) begin
                n_cmp++;
                if ({m_idx_o, m_data_o, m_last_o} !== {exp_idx(), exp_q[0], exp_idx() == 4'(NR-1)}) begin
                    n_err++;
                    $display("FAIL sb_beat c=%0d: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             c, m_idx_o, m_data_o, m_last_o, exp_idx(), exp_q[0], exp_idx() == 4'(NR-1));
                end
            end
            beats += int'(m_valid_o);
            start_i = (c == 0) || (act && exp_idx() == 4'd7);
            m_ready_i = 1'b1;
            if (act && exp_idx() == 4'd7) for (int k = 0; k < NR; k++) regs_m[k] = ~regs_m[k];
            model_edge();
        end
        n_cmp++;
        if (beats !== NR) begin
            n_err++;
            $display("FAIL sb_beat_count: beats=%0d required %0d", beats, NR);
        end
    endtask

    task automatic test_back_to_back();
        bit act;
        bit second = 1'b0;
        int dones = 0;
        for (int k = 0; k < NR; k++) regs_m[k] = $urandom;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            act = (exp_q.size() != 0);
            dones += int'(done_o);
            n_cmp++;
            if ({busy_o, m_valid_o, done_o} !== {act, act, exp_done}) begin
                n_err++;
                $display("FAIL b2b_ctrl c=%0d: busy/valid/done=%b%b%b required %b%b%b",
                         c, busy_o, m_valid_o, done_o, act, act, exp_done);
            end
            if (act) begin
                n_cmp++;
                if ({m_idx_o, m_data_o, m_last_o} !== {exp_idx(), exp_q[0], exp_idx() == 4'(NR-1)}) begin
                    n_err++;
                    $display("FAIL b2b_beat c=%0d: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             c, m_idx_o, m_data_o, m_last_o, exp_idx(), exp_q[0], exp_idx() == 4'(NR-1));
                end
            end
            start_i = (c == 0);
            m_ready_i = 1'b1;
            if (exp_done && !second) begin
                second = 1'b1;
                start_i = 1'b1;
                for (int k = 0; k < NR; k++) regs_m[k] = 32'h5555_0000 + k;
            end
            model_edge();
        end
        n_cmp++;
        if (dones !== 2) begin
            n_err++;
            $display("FAIL b2b_dones: done pulses=%0d required 2", dones);
        end
    endtask

    task automatic test_mid_reset();
        bit act;
        bit rst_prev = 1'b0;
        int rst_c = -10;
        int dones = 0;
        for (int k = 0; k < NR; k++) regs_m[k] = $urandom;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            act = (exp_q.size() != 0);
            dones += int'(done_o);
            n_cmp++;
            if ({busy_o, m_valid_o, done_o} !== {act, act, exp_done}) begin
                n_err++;
                $display("FAIL mr_ctrl c=%0d: busy/valid/done=%b%b%b required %b%b%b",
                         c, busy_o, m_valid_o, done_o, act, act, exp_done);
            end
            if (act) begin
                n_cmp++;
                if ({m_idx_o, m_data_o, m_last_o} !== {exp_idx(), exp_q[0], exp_idx() == 4'(NR-1)}) begin
                    n_err++;
                    $display("FAIL mr_beat c=%0d: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             c, m_idx_o, m_data_o, m_last_o, exp_idx(), exp_q[0], exp_idx() == 4'(NR-1));
                end
            end
            if (rst_prev) begin
                n_cmp++;
                if ({m_valid_o, busy_o, done_o, m_idx_o} !== 7'd0) begin
                    n_err++;
                    $display("FAIL mr_after_reset: valid=%b busy=%b done=%b idx=%0d required all 0",
                             m_valid_o, busy_o, done_o, m_idx_o);
                end
            end
            rst_prev = 1'b0;
            rst_n = 1'b1;
            m_ready_i = 1'b1;
            start_i = (c == 0) || (c == rst_c + 3);
            if (act && exp_idx() == 4'd9 && rst_c < 0) begin
                rst_n = 1'b0;
                rst_prev = 1'b1;
                rst_c = c;
            end
            model_edge();
        end
        n_cmp++;
        if (dones !== 1 || rst_c < 0) begin
            n_err++;
            $display("FAIL mr_dones: done pulses=%0d reset_cycle=%0d required 1 pulse after a reset", dones, rst_c);
        end
    endtask

    task automatic test_random();
        bit act;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            act = (exp_q.size() != 0);
            n_cmp++;
            if ({busy_o, m_valid_o, done_o} !== {act, act, exp_done}) begin
                n_err++;
                $display("FAIL rnd_ctrl c=%0d: busy/valid/done=%b%b%b required %b%b%b",
                         c, busy_o, m_valid_o, done_o, act, act, exp_done);
            end
            if (act) begin
                n_cmp++;
                if ({m_idx_o, m_data_o, m_last_o} !== {exp_idx(), exp_q[0], exp_idx() == 4'(NR-1)}) begin
                    n_err++;
                    $display("FAIL rnd_beat c=%0d: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             c, m_idx_o, m_data_o, m_last_o, exp_idx(), exp_q[0], exp_idx() == 4'(NR-1));
                end
            end
            m_ready_i = ($urandom_range(0, 2) != 0);
            start_i   = ($urandom_range(0, 5) == 0);
            rst_n     = ($urandom_range(0, 150) != 0);
            regs_m[$urandom_range(0, NR-1)] = $urandom;
            model_edge();
        end
    endtask

    initial begin
        for (int k = 0; k < NR; k++) regs_m[k] = '0;
        test_reset();
        test_basic();
        test_coherence();
        test_backpressure();
        test_start_busy();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Streaming read-out engine for a register file. On a start pulse it captures a coherent snapshot of every register and sends each one, in index order, over a valid/ready stream. It sits beside `regfile` instances and feeds debug, scan and trace paths that need the whole register state without stalling the writers.

## Interface
- `NUM_REGS`, default 16: number of registers in the snapshot; must be ≥ 2.
- `REG_WIDTH`, default 32: width of each register in bits.
- `IDX_W` (localparam), value `$clog2(NUM_REGS)`: width of the index output.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `start_i`  in  1  request a dump; sampled only in IDLE.
- `regs_i`  in  `NUM_REGS*REG_WIDTH`  flattened live register contents; register k is at bits `[k*REG_WIDTH +: REG_WIDTH]`.
- `busy_o`  out  1  high while a dump is in progress (state SEND).
- `done_o`  out  1  one-cycle pulse after the final beat is accepted.
- `m_valid_o`  out  1  stream beat valid.
- `m_ready_i`  in  1  downstream ready.
- `m_data_o`  out  `REG_WIDTH`  snapshot value for the current beat.
- `m_idx_o`  out  `IDX_W`  register index for the current beat.
- `m_last_o`  out  1  high on the beat where `m_idx_o == NUM_REGS-1`.

## Operation
- There are two states, IDLE and SEND, plus an internal snapshot array and an index counter.
- **IDLE, `start_i=1`**
  - Copy all of `regs_i` into the snapshot.
  - Set idx to 0 and move to SEND.
- **IDLE, `start_i=0`**: hold all state.
- **SEND**
  - `m_valid_o=1`, `m_data_o=snapshot[idx]`, `m_idx_o=idx`, `m_last_o=(idx==NUM_REGS-1)`.
  - A handshake is `m_valid_o && m_ready_i`.
  - On a handshake with idx < NUM_REGS-1: idx increments by 1.
  - On a handshake with idx == NUM_REGS-1: move to IDLE, set `done_o=1` for the next cycle, and return idx to 0.
- **Outputs in IDLE**: `m_valid_o=0`, `m_last_o=0`, `busy_o=0`. `m_data_o` and `m_idx_o` are don't-care; the implementation drives 0.
- **Stream rules**
  - `m_valid_o` never drops without a handshake.
  - `m_data_o`, `m_idx_o` and `m_last_o` stay stable while valid is high and ready is low.
  - The block never waits on `m_ready_i` before asserting valid.
- **Snapshot**: the snapshot is frozen for the entire dump. Changes on `regs_i` after the capture edge have no effect on emitted data.
- **`start_i` while busy**: ignored. It is not queued.
- **No combinational paths** from `m_ready_i` or `start_i` to any output. All outputs are registered or decoded from registered state.

## Timing
- **Reset values**: `busy_o=0`, `done_o=0`, `m_valid_o=0`, `m_last_o=0`, `m_data_o=0`, `m_idx_o=0`, state IDLE, snapshot cleared.
- **Reset mid-dump**: the dump is aborted with no `done_o` and the reset values above are applied on the next edge.
- **Start latency**: `start_i` sampled at edge T gives `busy_o=1` and `m_valid_o=1` with idx 0 after edge T. A start in cycle C therefore produces the first beat in cycle C+1.
- **Throughput**: one beat per cycle while `m_ready_i=1`. The minimum dump length is NUM_REGS cycles from the first valid to the last handshake.
- **Completion**: a final handshake at edge E gives `done_o=1`, `busy_o=0` and `m_valid_o=0` in the cycle after E. `done_o` clears one cycle later.
- **Simultaneous done and start**: `start_i` high during the `done_o` cycle is accepted, because the block is already in IDLE. The new snapshot is taken at that edge, so back-to-back dumps have one idle cycle between them.
- **Backpressure on the last beat**: the last beat holds indefinitely with `m_last_o=1` until ready is seen.

## Test plan
- **Basic dump**: NUM_REGS=16, `regs_i[k]=32'hA000_0000+k`, `m_ready_i=1`, one-cycle start → 16 consecutive beats with idx 0..15 and data A000_0000..A000_000F; `m_last_o` only on idx 15; `done_o` one cycle later; `busy_o` high for exactly 16 cycles.
- **Snapshot coherence**: start with all regs = 32'h1111_1111, then set all regs to 32'h2222_2222 in the cycle after start → all 16 beats carry 1111_1111.
- **Backpressure**: `m_ready_i` toggles 1,0,0,1 repeating, plus a 5-cycle stall on idx 15 → data, idx and last stay stable during every stall; no beat is skipped or duplicated; dump completes with `done_o` after the idx 15 handshake.
- **Start while busy**: pulse `start_i` at idx 7 → ignored; exactly 16 beats; no second dump follows.
- **Back-to-back**: `start_i` asserted in the `done_o` cycle, after regs were changed to 32'h5555_0000+k → the second dump begins the next cycle with the new values.
- **Mid-dump reset**: `rst_n=0` for one cycle at idx 9 → next cycle `m_valid_o=0`, `busy_o=0`, `done_o=0`, `m_idx_o=0`; a fresh start afterwards produces a full dump from idx 0.
